eth_serial_rx: RTL and testbench

Parametrised serial Ethernet frame receiver and the successor to the fixed-width Ethernet deframer.
- Hunts for preamble/SFD on a 1-bit line and parses the destination, source and length fields.
- Streams payload out as bytes with valid/last framing, checks CRC-32 FCS, filters on destination MAC.
- Reports per-frame status.
- Sits between the serial line sampler and the byte-oriented upper layer.

---
 rtl/eth_pkg.sv | 33 +++
 rtl/eth_serial_rx_if.sv | 35 +++
 rtl/eth_crc32_serial.sv | 29 ++
 rtl/eth_serial_rx.sv | 206 ++++++++++++++++++++
 tb/tb_eth_serial_rx.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared types and constants for the
// serial Ethernet receive path.
package eth_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_DST,
        S_SRC,
        S_LEN,
        S_PAY,
        S_FCS
    } state_t;

    localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [47:0] BCAST_ADDR = 48'hFFFFFFFFFFFF;

    localparam int DST_W = 48;
    localparam int SRC_W = 48;
    localparam int LEN_W = 16;
    localparam int FCS_W = 32;

    // One MSB-first, non-reflected CRC-32 step
    function automatic logic [31:0] crc32_step(
        input logic [31:0] crc,
        input logic        din
    );
        logic fb;
        fb = crc[31] ^ din;
        return {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/eth_serial_rx_if.sv
// eth_serial_rx_if: serial line in, payload bytes
// and per-frame status out.
interface eth_serial_rx_if;

    logic        input1;
    logic        in_valid;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_last;
    logic [47:0] dst_addr;
    logic [47:0] src_addr;
    logic [15:0] length;
    logic        frame_done;
    logic        frame_ok;
    logic        err_fcs;
    logic        err_len;
    logic        err_addr;

    modport master (
        output input1, in_valid,
        input  data_out, data_valid, data_last,
        input  dst_addr, src_addr, length,
        input  frame_done, frame_ok,
        input  err_fcs, err_len, err_addr
    );

    modport slave (
        input  input1, in_valid,
        output data_out, data_valid, data_last,
        output dst_addr, src_addr, length,
        output frame_done, frame_ok,
        output err_fcs, err_len, err_addr
    );

endinterface

// File: rtl/eth_crc32_serial.sv
// eth_crc32_serial: bit-serial CRC-32 LFSR,
// shared by the receive and transmit paths.
module eth_crc32_serial
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        enable,
    input  logic        din,
    output logic [31:0] crc_out
);

    logic [31:0] crc;

    // Reseed on init, otherwise fold in one bit per enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= crc32_step(crc, din);
        end
    end

    assign crc_out = crc;

endmodule

// File: rtl/eth_serial_rx.sv
// eth_serial_rx: serial Ethernet deframer with
// preamble hunt, address filter and FCS check.
module eth_serial_rx
    import eth_pkg::*;
#(
    parameter int          MAX_PAYLOAD_BYTES = 1500,
    parameter int          PRE_MIN           = 62,
    parameter logic [47:0] MAC_ADDR          = 48'h020000000001,
    parameter bit          FILTER_EN         = 1'b1,
    parameter bit          CHECK_FCS         = 1'b1
) (
    input logic            clk,
    input logic            reset,
    eth_serial_rx_if.slave bus
);

    localparam logic [5:0]  PRE_MIN_C = 6'(PRE_MIN);
    localparam logic [15:0] MAX_LEN   = 16'(MAX_PAYLOAD_BYTES);
    localparam logic [5:0]  DST_END   = 6'(DST_W - 1);
    localparam logic [5:0]  SRC_END   = 6'(SRC_W - 1);
    localparam logic [5:0]  LEN_END   = 6'(LEN_W - 1);
    localparam logic [5:0]  BYTE_END  = 6'd7;
    localparam logic [5:0]  FCS_END   = 6'(FCS_W - 1);

    state_t      st, nxt;
    logic [5:0]  bit_cnt;
    logic [5:0]  alt_cnt;
    logic        prev;
    logic [46:0] sr;
    logic [15:0] byte_cnt;
    logic [31:0] crc;

    logic        bit_in, adv;
    logic        field_end, crc_seed, crc_en;
    logic        sfd, len_bad, addr_ok, fcs_bad, last_byte;
    logic [15:0] len_new;
    logic [31:0] fcs_new;
    logic [7:0]  byte_new;

    logic [7:0]  data_q;
    logic        dv_q, dl_q;
    logic [47:0] dst_q, src_q;
    logic [15:0] len_q;
    logic        done_q, ok_q, efcs_q, elen_q, eaddr_q;

    assign bit_in    = bus.input1;
    assign adv       = bus.in_valid;
    assign len_new   = {sr[14:0], bit_in};
    assign fcs_new   = {sr[30:0], bit_in};
    assign byte_new  = {sr[6:0], bit_in};
    assign len_bad   = (len_new == '0) || (len_new > MAX_LEN);
    assign sfd       = bit_in && prev && (alt_cnt >= PRE_MIN_C);
    assign addr_ok   = !FILTER_EN || (dst_q == MAC_ADDR)
                       || (dst_q == BCAST_ADDR);
    assign fcs_bad   = CHECK_FCS && (fcs_new != ~crc);
    assign last_byte = (byte_cnt == len_q - 16'd1);

    eth_crc32_serial u_crc (
        .clk     (clk),
        .reset   (reset),
        .init    (crc_seed),
        .enable  (crc_en),
        .din     (bit_in),
        .crc_out (crc)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= S_HUNT;
        else        st <= nxt;
    end

    // Next state, field boundaries and CRC control
    always_comb begin
        nxt       = st;
        crc_seed  = 1'b0;
        crc_en    = 1'b0;
        field_end = 1'b0;
        if (adv) begin
            unique case (st)
                S_HUNT: begin
                    if (sfd) begin
                        nxt      = S_DST;
                        crc_seed = 1'b1;
                    end
                end
                S_DST: begin
                    crc_en    = 1'b1;
                    field_end = (bit_cnt == DST_END);
                    if (field_end) nxt = S_SRC;
                end
                S_SRC: begin
                    crc_en    = 1'b1;
                    field_end = (bit_cnt == SRC_END);
                    if (field_end) nxt = S_LEN;
                end
                S_LEN: begin
                    crc_en    = 1'b1;
                    field_end = (bit_cnt == LEN_END);
                    if (field_end) nxt = len_bad ? S_HUNT : S_PAY;
                end
                S_PAY: begin
                    crc_en    = 1'b1;
                    field_end = (bit_cnt == BYTE_END);
                    if (field_end && last_byte) nxt = S_FCS;
                end
                S_FCS: begin
                    field_end = (bit_cnt == FCS_END);
                    if (field_end) nxt = S_HUNT;
                end
                default: nxt = S_HUNT;
            endcase
        end
    end

    // Shift-in, preamble counting, field latches and strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            alt_cnt  <= '0;
            prev     <= 1'b0;
            sr       <= '0;
            byte_cnt <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            dl_q     <= 1'b0;
            dst_q    <= '0;
            src_q    <= '0;
            len_q    <= '0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            efcs_q   <= 1'b0;
            elen_q   <= 1'b0;
            eaddr_q  <= 1'b0;
        end else begin
            dv_q    <= 1'b0;
            dl_q    <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            efcs_q  <= 1'b0;
            elen_q  <= 1'b0;
            eaddr_q <= 1'b0;
            if (adv) begin
                sr      <= {sr[45:0], bit_in};
                bit_cnt <= (st == S_HUNT || field_end)
                           ? '0 : bit_cnt + 6'd1;
                if (st == S_HUNT) begin
                    if (sfd) begin
                        alt_cnt <= '0;
                        prev    <= 1'b0;
                    end else begin
                        prev <= bit_in;
                        if (bit_in != prev)
                            alt_cnt <= (alt_cnt == 6'd63)
                                       ? alt_cnt : alt_cnt + 6'd1;
                        else
                            alt_cnt <= 6'd1;
                    end
                end
                if (field_end) begin
                    unique case (st)
                        S_DST: dst_q <= {sr, bit_in};
                        S_SRC: src_q <= {sr, bit_in};
                        S_LEN: begin
                            len_q    <= len_new;
                            byte_cnt <= '0;
                            if (len_bad) begin
                                done_q  <= 1'b1;
                                elen_q  <= 1'b1;
                                eaddr_q <= !addr_ok;
                            end
                        end
                        S_PAY: begin
                            byte_cnt <= byte_cnt + 16'd1;
                            if (addr_ok) begin
                                data_q <= byte_new;
                                dv_q   <= 1'b1;
                                dl_q   <= last_byte;
                            end
                        end
                        S_FCS: begin
                            done_q  <= 1'b1;
                            efcs_q  <= fcs_bad;
                            eaddr_q <= !addr_ok;
                            ok_q    <= !(fcs_bad || !addr_ok);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = dv_q;
    assign bus.data_last  = dl_q;
    assign bus.dst_addr   = dst_q;
    assign bus.src_addr   = src_q;
    assign bus.length     = len_q;
    assign bus.frame_done = done_q;
    assign bus.frame_ok   = ok_q;
    assign bus.err_fcs    = efcs_q;
    assign bus.err_len    = elen_q;
    assign bus.err_addr   = eaddr_q;

endmodule

// File: tb/tb_eth_serial_rx.sv
// tb_eth_serial_rx: frame-level reference model feeding a
// scoreboard, checked by an independent output monitor.
module tb_eth_serial_rx;

    localparam logic [47:0] MAC   = 48'h020000000001;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam int          MAXP  = 1500;
    localparam int          PREM  = 62;

    typedef logic [7:0] bytes_t[$];

    typedef struct {
        bit          is_done;
        logic [7:0]  data;
        bit          last;
        bit          ok;
        bit          efcs;
        bit          elen;
        bit          eaddr;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] len;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    eth_serial_rx_if bus();

    eth_serial_rx #(
        .MAX_PAYLOAD_BYTES (MAXP),
        .PRE_MIN           (PREM),
        .MAC_ADDR          (MAC),
        .FILTER_EN         (1'b1),
        .CHECK_FCS         (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t me;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endfunction

    // Byte-wise CRC-32 of a message, MSB-first, init all-ones
    function automatic logic [31:0] ref_crc(input bytes_t m);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (m[i]) begin
            r = r ^ {m[i], 24'h0};
            for (int k = 0; k < 8; k++)
                r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        end
        return r;
    endfunction

    task automatic send_bit(input bit b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.input1   = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.input1   = b;
    endtask

    // Build a frame, predict its outputs, then drive it
    // (only the first cut bits when cut >= 0)
    task automatic send_frame(input int pre_n,
                              input logic [47:0] dst,
                              input logic [47:0] src,
                              input logic [15:0] len,
                              input bytes_t pl,
                              input int flip,
                              input bit gaps,
                              input int cut);
        bit          bits[$];
        bytes_t      body;
        logic [31:0] fcs;
        exp_t        e;
        bit          acc, bad;
        int          p0, nsend, idx;
        acc = (dst == MAC) || (dst == BCAST);
        bad = (len == 16'd0) || (len > 16'(MAXP));
        for (int i = 0; i < 6; i++) body.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) body.push_back(src[47-8*i -: 8]);
        body.push_back(len[15:8]);
        body.push_back(len[7:0]);
        if (!bad) foreach (pl[i]) body.push_back(pl[i]);
        for (int i = 0; i < pre_n; i++) bits.push_back(i % 2 == 0);
        bits.push_back(1'b1);
        bits.push_back(1'b1);
        p0 = bits.size();
        foreach (body[i])
            for (int k = 7; k >= 0; k--) bits.push_back(body[i][k]);
        if (!bad) begin
            fcs = ~ref_crc(body);
            if (flip >= 0) fcs[31-flip] = ~fcs[31-flip];
            for (int k = 31; k >= 0; k--) bits.push_back(fcs[k]);
        end
        nsend = (cut >= 0 && cut < bits.size()) ? cut : bits.size();
        if (pre_n >= PREM) begin
            if (!bad && acc) begin
                foreach (pl[i]) begin
                    idx = p0 + 112 + 8 * i + 7;
                    e = '{default: '0};
                    e.data = pl[i];
                    e.last = (i == int'(len) - 1);
                    if (idx < nsend) sb.push_back(e);
                end
            end
            e = '{default: '0};
            e.is_done = 1'b1;
            e.elen    = bad;
            e.efcs    = !bad && (flip >= 0);
            e.eaddr   = !acc;
            e.ok      = !(e.elen || e.efcs || e.eaddr);
            e.dst     = dst;
            e.src     = src;
            e.len     = len;
            idx = bad ? p0 + 111 : bits.size() - 1;
            if (idx < nsend) sb.push_back(e);
        end
        for (int i = 0; i < nsend; i++) send_bit(bits[i], gaps);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk(nm, sb.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data_out"}, bus.data_out, 0);
        chk({tag, "_strobes"},
            {bus.data_valid, bus.data_last, bus.frame_done}, 0);
        chk({tag, "_dst"}, bus.dst_addr, 0);
        chk({tag, "_src"}, bus.src_addr, 0);
        chk({tag, "_len"}, bus.length, 0);
        chk({tag, "_flags"}, {bus.frame_ok, bus.err_fcs,
                              bus.err_len, bus.err_addr}, 0);
    endtask

    // Monitor: pop and compare on every strobe
    always @(negedge clk) begin
        if (reset && !bus.frame_done)
            chk("flags_idle", {bus.frame_ok, bus.err_fcs,
                               bus.err_len, bus.err_addr}, 0);
        if (reset && !bus.data_valid)
            chk("last_idle", bus.data_last, 0);
        if (bus.data_valid || bus.frame_done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: dv=%0b done=%0b, expected none",
                         bus.data_valid, bus.frame_done);
            end else begin
                me = sb.pop_front();
                chk("evt_kind", {bus.data_valid, bus.frame_done},
                    me.is_done ? 2'b01 : 2'b10);
                if (!me.is_done) begin
                    chk("data_out", bus.data_out, me.data);
                    chk("data_last", bus.data_last, me.last);
                end else begin
                    chk("frame_ok", bus.frame_ok, me.ok);
                    chk("err_fcs", bus.err_fcs, me.efcs);
                    chk("err_len", bus.err_len, me.elen);
                    chk("err_addr", bus.err_addr, me.eaddr);
                    chk("dst_addr", bus.dst_addr, me.dst);
                    chk("src_addr", bus.src_addr, me.src);
                    chk("length", bus.length, me.len);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bytes_t      pl, none, p;
        logic [47:0] src, d, s;
        logic [15:0] l;
        int          fl, sel, pre;
        bus.input1   = 1'b0;
        bus.in_valid = 1'b0;
        src = 48'h0A0B0C0D0E0F;
        pl  = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        send_frame(62, MAC, src, 16'd4, pl, -1, 1'b0, -1);
        drain("drain_good");
        send_frame(62, MAC, src, 16'd4, pl, 5, 1'b0, -1);
        drain("drain_fcs");
        send_frame(62, 48'h020000000002, src, 16'd4, pl, -1, 1'b0, -1);
        drain("drain_addr");
        send_frame(64, BCAST, src, 16'd4, pl, -1, 1'b0, -1);
        drain("drain_bcast");

        send_frame(62, MAC, src, 16'd0, none, -1, 1'b0, -1);
        send_frame(62, MAC, src, 16'd1501, none, -1, 1'b0, -1);
        send_frame(62, MAC, src, 16'd4, pl, -1, 1'b0, -1);
        drain("drain_len");

        send_frame(PREM - 2, MAC, src, 16'd4, pl, -1, 1'b0, PREM);
        send_frame(62, MAC, 48'h111111111111, 16'd4, pl, -1, 1'b1, -1);
        drain("drain_short_pre");

        send_frame(62, MAC, src, 16'd4, pl, -1, 1'b0, 62 + 2 + 112 + 19);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_zero("midreset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        drain("drain_midreset");
        send_frame(62, MAC, src, 16'd4, pl, -1, 1'b0, -1);
        drain("drain_after_reset");

        for (int f = 0; f < 25; f++) begin
            p.delete();
            sel = $urandom_range(0, 9);
            if (sel < 5) d = MAC;
            else if (sel < 7) d = BCAST;
            else begin
                d = {16'($urandom), 32'($urandom)};
                if (d == MAC) d[0] = ~d[0];
            end
            s = {16'($urandom), 32'($urandom)};
            if ($urandom_range(0, 9) == 0) begin
                d = MAC;
                l = ($urandom_range(0, 1) == 1)
                    ? 16'd0 : 16'(1501 + $urandom_range(0, 500));
            end else begin
                l = 16'($urandom_range(1, 12));
                for (int i = 0; i < int'(l); i++) p.push_back(8'($urandom));
            end
            fl  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : -1;
            pre = ($urandom_range(0, 1) == 1) ? 62 : 64;
            send_frame(pre, d, s, l, p, fl, 1'($urandom_range(0, 1)), -1);
        end
        drain("drain_random");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
